// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared constants, pin-mode encoding and per-pin output helper
//            for the 8-channel PWM output stage.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // PWM counter width; duty resolution is 1/2**PWM_CNT_W
  localparam int PWM_CNT_W = 8;

  // Duty value that means "always high" instead of 255/256
  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_MAX = 8'hFF;

  // Number of output pins
  localparam int PWM_NUM_CH = 8;

  // Default clk cycles per PWM counter step
  localparam int PWM_PRESCALE_DEFAULT = 12;

  // How a single pin is driven, decoded from its enable/mode bits
  typedef enum logic [1:0] {
    PIN_OFF    = 2'd0,
    PIN_STATIC = 2'd1,
    PIN_PWM    = 2'd2
  } pin_mode_e;

  // Decode one pin's enable and mode bits into a drive mode
  function automatic pin_mode_e pin_mode(input logic i_en, input logic i_pwm);
    pin_mode_e m;
    if (!i_en) begin
      m = PIN_OFF;
    end else if (i_pwm) begin
      m = PIN_PWM;
    end else begin
      m = PIN_STATIC;
    end
    return m;
  endfunction

  // Pin level for a given mode and the shared PWM compare result
  function automatic logic pin_level(input pin_mode_e i_mode, input logic i_raw);
    logic lvl;
    case (i_mode)
      PIN_STATIC: lvl = 1'b1;
      PIN_PWM:    lvl = i_raw;
      default:    lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_prescaler
// Purpose  : Free-running divider. Counts 0..PRESCALE-1 and asserts tick for
//            the single clk on which the count is PRESCALE-1. With
//            PRESCALE=1 tick is high every clk. Intended for reuse by other
//            timed peripherals.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_prescaler #(
  parameter int PRESCALE = 12
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // Counter width; at least one bit so PRESCALE=1 still elaborates
  localparam int c_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_W-1:0] c_LAST = c_W'(PRESCALE - 1);

  logic [c_W-1:0] r_cnt;
  logic           w_tick;

  // Terminal count detect; combinational so the tick lands on count==LAST
  always_comb begin
    w_tick = (r_cnt == c_LAST);
  end

  // Divider count, wrapping to zero on the tick cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_W'(1);
    end
  end

  assign tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_generator
// Purpose  : Drives 8 output pins from the enable / mode / duty registers.
//            A shared PWM counter, stepped by pwm_prescaler, is compared
//            against a shadowed duty value. Each pin is off, static high or
//            PWM-modulated.
// Options  : PWM_SHADOW_UPDATE_EN - when defined, shadow registers reload
//            only at the counter wrap (and on the first clk after reset),
//            giving glitch-free period boundaries. When undefined they
//            reload every clk and changes apply after one register delay.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE_DEFAULT,
  parameter int CNT_W    = PWM_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PWM_NUM_CH-1:0] en_out,
  input  logic [PWM_NUM_CH-1:0] en_pwm,
  input  logic [CNT_W-1:0]      duty,
  output logic [PWM_NUM_CH-1:0] pwm_out,
  output logic                  period_start
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_load;
  logic                  w_raw;
  logic [PWM_NUM_CH-1:0] w_pin_next;

  logic [CNT_W-1:0]      r_pwm_cnt;
  logic                  r_period_start;
  logic [PWM_NUM_CH-1:0] r_en_s;
  logic [PWM_NUM_CH-1:0] r_pwm_s;
  logic [CNT_W-1:0]      r_duty_s;
  logic [PWM_NUM_CH-1:0] r_pwm_out;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Wrap is the tick that takes the counter from its max value back to 0
  always_comb begin
    w_wrap = w_tick & (r_pwm_cnt == c_CNT_MAX);
  end

  // Shared PWM counter, one step per prescaler tick, natural mod-2**CNT_W wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + CNT_W'(1);
    end
  end

  // Period marker: high for the clk on which the counter reads 0 after a wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_wrap;
    end
  end

`ifdef PWM_SHADOW_UPDATE_EN
  logic r_first;

  // First-clk-after-reset flag so the shadows pick up the inputs immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
    end
  end

  // Reload only at a period boundary, so a period is never cut or stretched
  always_comb begin
    w_load = r_first | w_wrap;
  end
`else
  // Reload every clk; input changes show up after one register delay
  always_comb begin
    w_load = 1'b1;
  end
`endif

  // Shadow copies of the inputs used by the compare stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_s   <= '0;
      r_pwm_s  <= '0;
      r_duty_s <= '0;
    end else if (w_load) begin
      r_en_s   <= en_out;
      r_pwm_s  <= en_pwm;
      r_duty_s <= duty;
    end
  end

  // Shared compare; the max duty is forced high to avoid a 1-step low glitch
  always_comb begin
    w_raw = (r_duty_s == c_CNT_MAX) | (r_pwm_cnt < r_duty_s);
  end

  // Per-pin drive level from the shadowed enable/mode bits
  always_comb begin
    w_pin_next = '0;
    for (int i = 0; i < PWM_NUM_CH; i++) begin
      w_pin_next[i] = pin_level(pin_mode(r_en_s[i], r_pwm_s[i]), w_raw);
    end
  end

  // Registered pin outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_out <= '0;
    end else begin
      r_pwm_out <= w_pin_next;
    end
  end

  assign pwm_out      = r_pwm_out;
  assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_generator
// Purpose  : Self-checking bench for pwm_generator with PRESCALE=12. A
//            cycle-count reference model derives counter, period marker and
//            pin levels from elapsed clk edges since reset release.
// Options  : PWM_SHADOW_UPDATE_EN selects the shadow-reload expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_generator;

  localparam int P   = 12;
  localparam int PER = 256 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] en_out = 8'h00;
  logic [7:0] en_pwm = 8'h00;
  logic [7:0] duty   = 8'h00;
  logic [7:0] pwm_out;
  logic       period_start;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int         k = 0;
  logic [7:0] m_en, m_pwm, m_duty, m_out;
  logic       m_ps;

  pwm_generator #(
    .PRESCALE (P),
    .CNT_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got running sim, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_out(input int cnt, input logic [7:0] e,
                                          input logic [7:0] pm, input logic [7:0] d);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) begin
      if (!e[i])            o[i] = 1'b0;
      else if (!pm[i])      o[i] = 1'b1;
      else if (d == 8'hFF)  o[i] = 1'b1;
      else                  o[i] = (cnt < int'(d));
    end
    return o;
  endfunction

  // Advance one clk edge, updating the model and checking both outputs
  task automatic step();
    int cnt;
    cnt   = (k / P) % 256;
    m_out = ref_out(cnt, m_en, m_pwm, m_duty);
    m_ps  = ((k % PER) == PER - 1);
`ifdef PWM_SHADOW_UPDATE_EN
    if (k == 0 || (k % PER) == PER - 1)
`endif
    begin
      m_en   = en_out;
      m_pwm  = en_pwm;
      m_duty = duty;
    end
    k++;
    @(posedge clk);
    #1;
    n_checks++;
    if (pwm_out !== m_out) begin
      n_fail++;
      $display("FAIL pwm_out k=%0d got %h required %h", k, pwm_out, m_out);
    end
    n_checks++;
    if (period_start !== m_ps) begin
      n_fail++;
      $display("FAIL period_start k=%0d got %b required %b", k, period_start, m_ps);
    end
  endtask

  task automatic model_clear();
    k      = 0;
    m_en   = 8'h00;
    m_pwm  = 8'h00;
    m_duty = 8'h00;
  endtask

  // Assert reset between edges, check outputs held low, release at negedge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (pwm_out !== 8'h00 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got %h/%b required 00/0", pwm_out, period_start);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (pwm_out !== 8'h00 || period_start !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold got %h/%b required 00/0", pwm_out, period_start);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    int n;
    en_out = 8'hFF; en_pwm = 8'hFF; duty = 8'h80;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pwm_out !== 8'h00 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial got %h/%b required 00/0", pwm_out, period_start);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (1000) step();
    do_reset();
    // first period after release must be a full 256 steps
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 4000);
    n_checks++;
    if (n != PER) begin
      n_fail++;
      $display("FAIL reset_restart first period got %0d clk required %0d", n, PER);
    end
  endtask

  task automatic test_half_duty();
    int hi, pulses;
    en_out = 8'h01; en_pwm = 8'h01; duty = 8'h80;
    do_reset();
    repeat (PER) step();
    hi = 0; pulses = 0;
    repeat (PER) begin
      step();
      if (pwm_out[0]) hi++;
      if (period_start) pulses++;
    end
    n_checks++;
    if (hi != PER / 2) begin
      n_fail++;
      $display("FAIL half_duty high clk got %0d required %0d", hi, PER / 2);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL period_pulses got %0d required 1", pulses);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] cfg_pwm [3];
    logic [7:0] cfg_duty[3];
    int         exp_hi  [3];
    int         hi;
    cfg_pwm[0] = 8'h01; cfg_duty[0] = 8'h00; exp_hi[0] = 0;
    cfg_pwm[1] = 8'h01; cfg_duty[1] = 8'hFF; exp_hi[1] = 3 * PER;
    cfg_pwm[2] = 8'h00; cfg_duty[2] = 8'h80; exp_hi[2] = 3 * PER;
    for (int c = 0; c < 3; c++) begin
      en_out = 8'h01; en_pwm = cfg_pwm[c]; duty = cfg_duty[c];
      do_reset();
      step();
      hi = 0;
      repeat (3 * PER) begin
        step();
        if (pwm_out[0]) hi++;
      end
      n_checks++;
      if (hi != exp_hi[c]) begin
        n_fail++;
        $display("FAIL extremes cfg%0d high clk got %0d required %0d", c, hi, exp_hi[c]);
      end
    end
  endtask

  task automatic test_mixed_pins();
    int hi[8];
    int exp_hi[8];
    exp_hi = '{0, PER / 4, 0, PER / 4, 0, PER, 0, PER};
    en_out = 8'hAA; en_pwm = 8'h0F; duty = 8'h40;
    do_reset();
    step();
    for (int i = 0; i < 8; i++) hi[i] = 0;
    repeat (PER) begin
      step();
      for (int i = 0; i < 8; i++) if (pwm_out[i]) hi[i]++;
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (hi[i] != exp_hi[i]) begin
        n_fail++;
        $display("FAIL mixed pin%0d high clk got %0d required %0d", i, hi[i], exp_hi[i]);
      end
    end
  endtask

  task automatic test_shadow();
    int   hi;
    logic exp_now;
    int   exp_rest;
    en_out = 8'h01; en_pwm = 8'h01; duty = 8'h40;
    do_reset();
    repeat (100 * P) step();
    duty = 8'hC0;
    repeat (2) step();
`ifdef PWM_SHADOW_UPDATE_EN
    exp_now  = 1'b0;
    exp_rest = 0;
`else
    exp_now  = 1'b1;
    exp_rest = 192 * P - (100 * P + 2);
`endif
    n_checks++;
    if (pwm_out[0] !== exp_now) begin
      n_fail++;
      $display("FAIL shadow_2clk got %b required %b", pwm_out[0], exp_now);
    end
    hi = 0;
    while (k < PER) begin
      step();
      if (pwm_out[0]) hi++;
    end
    n_checks++;
    if (hi != exp_rest) begin
      n_fail++;
      $display("FAIL shadow_rest high clk got %0d required %0d", hi, exp_rest);
    end
    hi = 0;
    repeat (PER) begin
      step();
      if (pwm_out[0]) hi++;
    end
    n_checks++;
    if (hi != 192 * P) begin
      n_fail++;
      $display("FAIL shadow_next high clk got %0d required %0d", hi, 192 * P);
    end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int s = 0; s < 10; s++) begin
      en_out = 8'($urandom);
      en_pwm = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       duty = 8'h00;
        1:       duty = 8'hFF;
        default: duty = 8'($urandom);
      endcase
      len = $urandom_range(1, 2000);
      repeat (len) step();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_half_duty();
    test_extremes();
    test_mixed_pins();
    test_shadow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
